// File: rtl/nrp_program_loader.sv
// Byte-stream program loader: parses HDR/ADDR/LEN/payload[/CSUM] frames into instruction/data memory writes, then releases the core on RUN.
// Latency: a payload byte accepted at edge k drives mem_we/addr/wdata in the following cycle; one byte per cycle sustained.
// Backpressure: in_ready is high in every parsing state and drops for good in S_RUN/S_ERR; NRP_LOADER_CSUM_EN adds a trailing checksum byte.
module nrp_program_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              RealClock,
    input  logic              Reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              seg_done,
    output logic              core_run,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_HDR,
        S_ADDR,
        S_LEN,
        S_DATA,
`ifdef NRP_LOADER_CSUM_EN
        S_CSUM,
`endif
        S_RUN,
        S_ERR
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base, base_nx;
    logic [ADDR_W:0]   cnt, cnt_nx;
    logic [ADDR_W:0]   idx, idx_nx;
    logic [ADDR_W:0]   idx_inc;
    logic              sel_nx, we_nx, done_nx, run_nx, err_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic              accept;
`ifdef NRP_LOADER_CSUM_EN
    logic [DATA_W-1:0] sum, sum_nx;
    logic              run_pend, run_pend_nx;
`endif

    assign in_ready = (state != S_RUN) && (state != S_ERR);
    assign accept   = in_valid && in_ready;
    assign idx_inc  = idx + 1'b1;

    always_ff @(posedge RealClock) begin
        if (!Reset) begin
            state     <= S_HDR;
            base      <= '0;
            cnt       <= '0;
            idx       <= '0;
            mem_we    <= 1'b0;
            mem_sel   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            seg_done  <= 1'b0;
            core_run  <= 1'b0;
            load_err  <= 1'b0;
`ifdef NRP_LOADER_CSUM_EN
            sum       <= '0;
            run_pend  <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            base      <= base_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            mem_we    <= we_nx;
            mem_sel   <= sel_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            seg_done  <= done_nx;
            core_run  <= run_nx;
            load_err  <= err_nx;
`ifdef NRP_LOADER_CSUM_EN
            sum       <= sum_nx;
            run_pend  <= run_pend_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        base_nx  = base;
        cnt_nx   = cnt;
        idx_nx   = idx;
        sel_nx   = mem_sel;
        we_nx    = 1'b0;
        addr_nx  = mem_addr;
        wdata_nx = mem_wdata;
        done_nx  = 1'b0;
        run_nx   = core_run;
        err_nx   = load_err;
`ifdef NRP_LOADER_CSUM_EN
        sum_nx      = sum;
        run_pend_nx = run_pend;
`endif
        if (accept) begin
`ifdef NRP_LOADER_CSUM_EN
            sum_nx = sum + in_data;
`endif
            unique case (state)
                S_HDR: begin
`ifdef NRP_LOADER_CSUM_EN
                    // Running sum restarts with each header byte.
                    sum_nx = in_data;
`endif
                    case (in_data[DATA_W-1 -: 2])
                        2'b00, 2'b01: begin
                            sel_nx   = in_data[DATA_W-2];
                            state_nx = S_ADDR;
`ifdef NRP_LOADER_CSUM_EN
                            run_pend_nx = 1'b0;
`endif
                        end
                        2'b10: begin
`ifdef NRP_LOADER_CSUM_EN
                            run_pend_nx = 1'b1;
                            state_nx    = S_CSUM;
`else
                            run_nx   = 1'b1;
                            state_nx = S_RUN;
`endif
                        end
                        default: begin
                            err_nx   = 1'b1;
                            state_nx = S_ERR;
                        end
                    endcase
                end
                S_ADDR: begin
                    base_nx  = ADDR_W'(in_data);
                    state_nx = S_LEN;
                end
                S_LEN: begin
                    // LEN of zero encodes a full 2^ADDR_W byte segment.
                    cnt_nx   = (in_data == '0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(in_data);
                    idx_nx   = '0;
                    state_nx = S_DATA;
                end
                S_DATA: begin
                    we_nx    = 1'b1;
                    addr_nx  = base + idx[ADDR_W-1:0];
                    wdata_nx = in_data;
                    idx_nx   = idx_inc;
                    if (idx_inc == cnt) begin
`ifdef NRP_LOADER_CSUM_EN
                        state_nx = S_CSUM;
`else
                        state_nx = S_HDR;
                        done_nx  = 1'b1;
`endif
                    end
                end
`ifdef NRP_LOADER_CSUM_EN
                S_CSUM: begin
                    if (sum_nx == '0) begin
                        if (run_pend) begin
                            run_nx   = 1'b1;
                            state_nx = S_RUN;
                        end else begin
                            done_nx  = 1'b1;
                            state_nx = S_HDR;
                        end
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = S_ERR;
                    end
                end
`endif
                default: begin
                    state_nx = state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nrp_program_loader.sv
// Self-checking bench for nrp_program_loader: directed frames plus randomized segments compared against a frame-level write model.
module tb_nrp_program_loader;

    logic       RealClock = 1'b0;
    logic       Reset     = 1'b0;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       in_ready;
    logic       mem_we;
    logic       mem_sel;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       seg_done;
    logic       core_run;
    logic       load_err;

    always #5 RealClock = ~RealClock;

    nrp_program_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .RealClock (RealClock),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .seg_done  (seg_done),
        .core_run  (core_run),
        .load_err  (load_err)
    );

    typedef struct packed {
        logic       sel;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        got_q[$];
    logic [7:0] pl[$];
    int         total   = 0;
    int         bad     = 0;
    int         seg_cnt = 0;
    int         exp_seg = 0;

    always @(negedge RealClock) begin
        if (mem_we === 1'b1) got_q.push_back({mem_sel, mem_addr, mem_wdata});
        if (seg_done === 1'b1) seg_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b, input int gap);
        repeat (gap) begin
            in_valid = 1'b0;
            @(posedge RealClock); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge RealClock); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge RealClock); #1;
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        Reset    = 1'b0;
        @(posedge RealClock); #1;
        Reset    = 1'b1;
    endtask

    // Reference: frame bytes built from the protocol rules; each payload byte i lands at (base+i) mod 256.
    task automatic send_seg(input logic sel, input logic [7:0] base, input int len, input int maxgap);
        logic [7:0] hdr, sum, a;
        hdr = {1'b0, sel, 6'($urandom)};
        sum = hdr;
        put(hdr, $urandom_range(0, maxgap));
        put(base, $urandom_range(0, maxgap));
        sum = sum + base;
        put(8'(len), $urandom_range(0, maxgap));
        sum = sum + 8'(len);
        for (int i = 0; i < len; i++) begin
            a = base + 8'(i);
            put(pl[i], $urandom_range(0, maxgap));
            sum = sum + pl[i];
            exp_q.push_back({sel, a, pl[i]});
            chk("wr_latency", {mem_we, mem_sel, mem_addr, mem_wdata}, {1'b1, sel, a, pl[i]});
        end
`ifdef NRP_LOADER_CSUM_EN
        put(8'h00 - sum, $urandom_range(0, maxgap));
`endif
        exp_seg++;
        chk("seg_done_pulse", {31'd0, seg_done}, 32'd1);
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_write"}, {15'd0, got_q[i]}, {15'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int len;
        Reset = 1'b0;
        @(posedge RealClock); #1;
        @(posedge RealClock); #1;
        chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst_mem_sel",   {31'd0, mem_sel},   32'd0);
        chk("rst_mem_addr",  {24'd0, mem_addr},  32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_seg_done",  {31'd0, seg_done},  32'd0);
        chk("rst_core_run",  {31'd0, core_run},  32'd0);
        chk("rst_load_err",  {31'd0, load_err},  32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        Reset = 1'b1;
        got_q.delete();
        seg_cnt = 0;

        pl = '{8'hC7, 8'h10};
        send_seg(1'b0, 8'h10, 2, 0);
        idle(2);
        cmp_writes("instr_seg");
        chk("instr_load_err", {31'd0, load_err}, 32'd0);

        pl = '{8'hAA, 8'h55};
        send_seg(1'b1, 8'hFF, 2, 0);
        idle(2);
        cmp_writes("addr_wrap");

        for (int k = 0; k < 5; k++) begin
            pl.delete();
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            send_seg(1'($urandom), 8'($urandom), len, 2);
            idle($urandom_range(0, 3));
            idle(2);
            cmp_writes("rand_seg");
        end

        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'($urandom));
        send_seg(1'($urandom), 8'($urandom), 256, 0);
        idle(2);
        cmp_writes("len_zero");
        chk("seg_count", seg_cnt, exp_seg);

        put(8'h00, 0);
        put(8'h20, 0);
        put(8'h04, 0);
        put(8'h01, 0);
        exp_q.push_back({1'b0, 8'h20, 8'h01});
        do_reset();
        chk("midrst_mem_we",   {31'd0, mem_we},   32'd0);
        chk("midrst_outs",     {22'd0, mem_sel, mem_addr, seg_done, core_run}, 32'd0);
        chk("midrst_wdata",    {23'd0, mem_wdata, load_err}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        pl = '{8'h99};
        send_seg(1'b0, 8'h30, 1, 0);
        idle(2);
        cmp_writes("after_midrst");

`ifdef NRP_LOADER_CSUM_EN
        put(8'h00, 0);
        put(8'h10, 0);
        put(8'h01, 0);
        put(8'h12, 0);
        exp_q.push_back({1'b0, 8'h10, 8'h12});
        put(8'h00, 0);
        chk("badcs_load_err", {31'd0, load_err}, 32'd1);
        chk("badcs_in_ready", {31'd0, in_ready}, 32'd0);
        chk("badcs_seg_done", {31'd0, seg_done}, 32'd0);
        put(8'h80, 0);
        put(8'h80, 0);
        idle(2);
        chk("badcs_no_run", {31'd0, core_run}, 32'd0);
        cmp_writes("badcs");
        do_reset();
`endif

        put(8'hC0 | 8'($urandom_range(0, 63)), 0);
        chk("rsvd_load_err", {31'd0, load_err}, 32'd1);
        chk("rsvd_mem_we",   {31'd0, mem_we},   32'd0);
        chk("rsvd_in_ready", {31'd0, in_ready}, 32'd0);
        put(8'h00, 0);
        put(8'h10, 0);
        put(8'h01, 0);
        put(8'h33, 0);
        idle(2);
        chk("rsvd_err_sticky", {31'd0, load_err}, 32'd1);
        cmp_writes("rsvd");
        do_reset();
        chk("rsvd_cleared", {31'd0, load_err}, 32'd0);

        put(8'h80, 0);
`ifdef NRP_LOADER_CSUM_EN
        chk("run_not_yet", {31'd0, core_run}, 32'd0);
        chk("run_hdr_rdy", {31'd0, in_ready}, 32'd1);
        put(8'h80, 0);
`endif
        chk("run_core_run", {31'd0, core_run}, 32'd1);
        chk("run_in_ready", {31'd0, in_ready}, 32'd0);
        chk("run_load_err", {31'd0, load_err}, 32'd0);
        put(8'h00, 0);
        put(8'h10, 0);
        put(8'h01, 0);
        put(8'h55, 0);
        put(8'h66, 0);
        idle(2);
        cmp_writes("run_ignored");
        chk("run_sticky", {31'd0, core_run}, 32'd1);
        chk("seg_count_final", seg_cnt, exp_seg);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nrp_program_loader.md
# nrp_program_loader

Byte-stream program loader for the nanoRisk processor: the writer side of the processor's instruction and data memories. It accepts framed segments over a byte-wide valid/ready stream and writes them into the 256 × 8 instruction or data memory. When a RUN frame is accepted, it releases the core from hold. The block sits between the host-facing link and the memory write ports, and owns them until the core is released.

## Interface
- `ADDR_W`, default 8: memory address width (256 locations).
- `DATA_W`, default 8: byte width of the stream and of memory words.
- `RealClock` in 1: the single clock. All state changes on its rising edge.
- `Reset` in 1: synchronous, active-low reset.
- `in_valid` in 1: the stream byte is present.
- `in_data` in 8: the stream byte.
- `in_ready` out 1: the loader accepts a byte. A byte transfers on a rising edge with `in_valid && in_ready`.
- `mem_we` out 1: one-cycle memory write strobe.
- `mem_sel` out 1: write target. 0 selects instruction memory, 1 selects data memory.
- `mem_addr` out 8: write address.
- `mem_wdata` out 8: write data.
- `seg_done` out 1: one-cycle pulse when a segment completes successfully.
- `core_run` out 1: level signal that releases the processor. Sticky until reset.
- `load_err` out 1: sticky error flag. Only reset clears it.

## Operation
- Frame layout: HDR, ADDR, LEN, N payload bytes, then CSUM (CSUM only when checksum checking is compiled in).
- HDR bits [7:6] give the command:
  - 00: write an instruction segment.
  - 01: write a data segment.
  - 10: RUN. The frame is HDR plus CSUM only.
  - 11: reserved.
- HDR bits [5:0] are ignored.
- LEN = 0 means 256 payload bytes.
- States are S_HDR, S_ADDR, S_LEN, S_DATA, S_CSUM, S_RUN, S_ERR. Transitions happen only on an accepted byte, except where noted.
  - S_HDR goes to S_ADDR for cmd 00/01.
  - S_HDR goes to S_CSUM for cmd 10. With checksum compiled out, it goes directly to S_RUN.
  - S_HDR goes to S_ERR for cmd 11.
  - S_ADDR latches the base address and goes to S_LEN.
  - S_LEN latches the count and goes to S_DATA.
  - S_DATA writes the byte to base+idx. After the last byte it goes to S_CSUM (or to S_HDR with checksum compiled out).
  - S_CSUM goes to S_HDR on a good write segment.
  - S_CSUM goes to S_RUN on a good RUN frame.
  - S_CSUM goes to S_ERR on a mismatch.
- `in_ready` is 1 in S_HDR through S_CSUM and 0 in S_RUN and S_ERR. Both S_RUN and S_ERR are terminal until reset.
- Address arithmetic is 8-bit and wraps: base+idx mod 256 (0xFF is followed by 0x00).
- Checksum: the 8-bit sum of every frame byte, including CSUM, must equal 0x00.
- Writes already issued before a checksum failure are not rolled back. `core_run` can never assert once `load_err` is set.
- Reset low at any rising edge, including mid-frame:
  - The state returns to S_HDR.
  - The index and running sum clear.
  - All registered outputs go to 0.
  - A partially received frame is discarded.
- Reset values: `mem_we`, `mem_sel`, `mem_addr`, `mem_wdata`, `seg_done`, `core_run` and `load_err` are all 0. `in_ready` is 1, because the state is S_HDR.

## Timing
- Throughput is one byte per cycle. `in_valid` gaps of any length are allowed and have no effect.
- Payload byte accepted at edge k:
  - `mem_we`, `mem_addr` and `mem_wdata` are valid from k to k+1 (one cycle of latency).
  - `mem_sel` is held for the whole segment.
- `seg_done` pulses in the cycle after the CSUM byte is accepted. With checksum compiled out, it pulses in the same cycle as the final `mem_we`.
- `core_run` rises in the cycle after the RUN frame's last byte is accepted.
- `load_err` rises in the cycle after the offending byte is accepted.

## Configuration
- The feature is controlled by the macro `NRP_LOADER_CSUM_EN`.
- When defined: the CSUM byte is required and verified, and a mismatch leads to S_ERR.
- When undefined:
  - There is no CSUM byte and the S_CSUM state does not exist.
  - The only way to set `load_err` is a reserved command.
  - A RUN frame is the single HDR byte 0x80.

## Test plan
- Instruction segment (macro on): stream 0x00,0x10,0x02,0xC7,0x10,0x17 → instruction writes 0xC7@0x10 and 0x10@0x11 on consecutive cycles; `seg_done` pulses once; `load_err` stays 0.
- Address wrap: stream 0x40,0xFF,0x02,0xAA,0x55,0xC0 → `mem_sel`=1; writes 0xAA@0xFF then 0x55@0x00.
- RUN frame: stream 0x80,0x80 → `core_run`=1 one cycle later; `in_ready`=0 thereafter; further bytes are ignored.
- Bad checksum: stream 0x00,0x10,0x01,0x12,0x00 → 0x12@0x10 is written; `load_err`=1; `in_ready`=0; a following 0x80,0x80 never asserts `core_run`.
- Reserved command: stream 0xC0 → S_ERR; `load_err`=1 on the next cycle; no `mem_we`.
- Reset mid-frame: drive `Reset` low after 0x00,0x20,0x04,0x01 → all outputs 0 and `in_ready`=1. A fresh 0x00,0x30,0x01,0x99,0x36 then writes 0x99@0x30 only. LEN=0 is also exercised: exactly 256 writes occur.
